// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, opcodes and helpers for the
// MIPS32 pipeline registers and hazard unit.
package mips_pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // What a pipeline register does on the next edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } pipe_act_e;

    // Tnew moves one stage closer to ready, never below zero.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        if (t == '0) r = '0;
        else         r = t - TW'(1);
        return r;
    endfunction

    // Primary opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/em_pipe_reg_perf_counter.sv
// perf_counter: free-running event counter with enable,
// wraps at 2^W, async active-low clear.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count one event per enabled edge; wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/em_pipe_reg.sv
// em_pipe_reg: E->M pipeline register of the 5-stage MIPS32 core.
// Optional event counters are built when EM_PERF_CNT_EN is defined.
module em_pipe_reg #(
    parameter int DW = mips_pipe_pkg::DW,
    parameter int RW = mips_pipe_pkg::RW,
    parameter int TW = mips_pipe_pkg::TW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_E,
    input  logic [DW-1:0] instr_E,
    input  logic [DW-1:0] pc_E,
    input  logic [DW-1:0] alu_out_E,
    input  logic [DW-1:0] rt_data_E,
    input  logic [RW-1:0] a3_E,
    input  logic [TW-1:0] tnew_E,
    output logic [DW-1:0] instr_M,
    output logic [DW-1:0] pc_M,
    output logic [DW-1:0] pc8_M,
    output logic [DW-1:0] alu_out_M,
    output logic [DW-1:0] rt_data_M,
    output logic [RW-1:0] a3_M,
    output logic [TW-1:0] tnew_M,
    output logic          valid_M
`ifdef EM_PERF_CNT_EN
    ,
    output logic [31:0]   bubble_cnt_M,
    output logic [31:0]   stall_cnt_M,
    output logic [31:0]   store_cnt_M
`endif
);

    import mips_pipe_pkg::*;

    pipe_act_e act;

    // Resolve flush > stall > load; an empty E slot becomes a bubble.
    always_comb begin
        act = ACT_BUBBLE;
        unique case (1'b1)
            flush:                      act = ACT_BUBBLE;
            !flush && stall:            act = ACT_HOLD;
            !flush && !stall && valid_E: act = ACT_LOAD;
            default:                    act = ACT_BUBBLE;
        endcase
    end

    // M-stage state: capture, hold, or clear to a NOP bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_M   <= DW'(NOP_INSTR);
            pc_M      <= '0;
            alu_out_M <= '0;
            rt_data_M <= '0;
            a3_M      <= '0;
            tnew_M    <= '0;
            valid_M   <= 1'b0;
        end else begin
            unique case (act)
                ACT_LOAD: begin
                    instr_M   <= instr_E;
                    pc_M      <= pc_E;
                    alu_out_M <= alu_out_E;
                    rt_data_M <= rt_data_E;
                    a3_M      <= a3_E;
                    tnew_M    <= tnew_dec(tnew_E);
                    valid_M   <= 1'b1;
                end
                ACT_HOLD: begin
                    instr_M   <= instr_M;
                    pc_M      <= pc_M;
                    alu_out_M <= alu_out_M;
                    rt_data_M <= rt_data_M;
                    a3_M      <= a3_M;
                    tnew_M    <= tnew_M;
                    valid_M   <= valid_M;
                end
                default: begin
                    instr_M   <= DW'(NOP_INSTR);
                    pc_M      <= '0;
                    alu_out_M <= '0;
                    rt_data_M <= '0;
                    a3_M      <= '0;
                    tnew_M    <= '0;
                    valid_M   <= 1'b0;
                end
            endcase
        end
    end

    // Link address for jal/jalr; wraps modulo 2^DW.
    assign pc8_M = pc_M + DW'(8);

`ifdef EM_PERF_CNT_EN
    logic bubble_en;
    logic stall_en;
    logic store_en;

    // Event strobes for the counters, one per edge at most.
    always_comb begin
        bubble_en = (act == ACT_BUBBLE);
        stall_en  = (act == ACT_HOLD);
        store_en  = (act == ACT_LOAD) &&
                    (opcode_of(32'(instr_E)) == OP_SW);
    end

    perf_counter #(.W(32)) u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bubble_en),
        .cnt     (bubble_cnt_M)
    );

    perf_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (stall_en),
        .cnt     (stall_cnt_M)
    );

    perf_counter #(.W(32)) u_store_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (store_en),
        .cnt     (store_cnt_M)
    );
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// tb_em_pipe_reg: scoreboard bench for em_pipe_reg with directed
// cases and randomized stall/flush/valid traffic.
module tb_em_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_E = 1'b0;
    logic [31:0] instr_E = '0;
    logic [31:0] pc_E = '0;
    logic [31:0] alu_out_E = '0;
    logic [31:0] rt_data_E = '0;
    logic [4:0]  a3_E = '0;
    logic [1:0]  tnew_E = '0;
    logic [31:0] instr_M, pc_M, pc8_M, alu_out_M, rt_data_M;
    logic [4:0]  a3_M;
    logic [1:0]  tnew_M;
    logic        valid_M;
`ifdef EM_PERF_CNT_EN
    logic [31:0] bubble_cnt_M, stall_cnt_M, store_cnt_M;
`endif

    em_pipe_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .valid_E   (valid_E),
        .instr_E   (instr_E),
        .pc_E      (pc_E),
        .alu_out_E (alu_out_E),
        .rt_data_E (rt_data_E),
        .a3_E      (a3_E),
        .tnew_E    (tnew_E),
        .instr_M   (instr_M),
        .pc_M      (pc_M),
        .pc8_M     (pc8_M),
        .alu_out_M (alu_out_M),
        .rt_data_M (rt_data_M),
        .a3_M      (a3_M),
        .tnew_M    (tnew_M),
        .valid_M   (valid_M)
`ifdef EM_PERF_CNT_EN
        ,
        .bubble_cnt_M (bubble_cnt_M),
        .stall_cnt_M  (stall_cnt_M),
        .store_cnt_M  (store_cnt_M)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint instr, pc, alu, rt, a3, tnew, valid;
        longint bc, sc, stc;
    } exp_t;

    exp_t q[$];
    exp_t mdl;
    int   total = 0;
    int   passed = 0;
    bit   in_reset = 1'b1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic longint pc8_of(input longint pc);
        return (pc + 8) % 64'h1_0000_0000;
    endfunction

    function automatic void mdl_clear_fields();
        mdl.instr = 0; mdl.pc = 0; mdl.alu = 0; mdl.rt = 0;
        mdl.a3 = 0; mdl.tnew = 0; mdl.valid = 0;
    endfunction

    // Set up E inputs for the coming edge and queue the M state it yields.
    task automatic drive(input bit st, input bit fl, input bit v,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] a3, input logic [1:0] tn);
        stall = st; flush = fl; valid_E = v;
        instr_E = ins; pc_E = pc; alu_out_E = alu; rt_data_E = rt;
        a3_E = a3; tnew_E = tn;
        if (fl || (!st && !v)) begin
            mdl_clear_fields();
            mdl.bc = (mdl.bc + 1) % 64'h1_0000_0000;
        end else if (st) begin
            mdl.sc = (mdl.sc + 1) % 64'h1_0000_0000;
        end else begin
            mdl.instr = ins; mdl.pc = pc; mdl.alu = alu; mdl.rt = rt;
            mdl.a3 = a3;
            mdl.tnew = (tn > 0) ? tn - 1 : 0;
            mdl.valid = 1;
            if (ins[31:26] == 6'd43) mdl.stc = (mdl.stc + 1) % 64'h1_0000_0000;
        end
        q.push_back(mdl);
    endtask

    task automatic cyc(input bit st, input bit fl, input bit v,
                       input logic [31:0] ins, input logic [31:0] pc,
                       input logic [4:0] a3, input logic [1:0] tn);
        @(negedge clk);
        drive(st, fl, v, ins, pc, $urandom, $urandom, a3, tn);
    endtask

    // Monitor: compare DUT state after every edge against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset && q.size() > 0) begin
                e = q.pop_front();
                chk("instr_M", instr_M, e.instr);
                chk("pc_M", pc_M, e.pc);
                chk("pc8_M", pc8_M, pc8_of(e.pc));
                chk("alu_out_M", alu_out_M, e.alu);
                chk("rt_data_M", rt_data_M, e.rt);
                chk("a3_M", a3_M, e.a3);
                chk("tnew_M", tnew_M, e.tnew);
                chk("valid_M", valid_M, e.valid);
`ifdef EM_PERF_CNT_EN
                chk("bubble_cnt_M", bubble_cnt_M, e.bc);
                chk("stall_cnt_M", stall_cnt_M, e.sc);
                chk("store_cnt_M", store_cnt_M, e.stc);
`endif
            end
        end
    end

    // Assert reset mid-cycle with busy inputs, check clear, then release.
    task automatic do_reset();
        @(posedge clk);
        #3;
        stall = 1'b1; flush = 1'b1; valid_E = 1'b1;
        instr_E = 32'h8C22_0004; pc_E = 32'h1234_5678;
        alu_out_E = 32'hDEAD_BEEF; rt_data_E = 32'hCAFE_F00D;
        a3_E = 5'd7; tnew_E = 2'd3;
        in_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst instr_M", instr_M, 0);
        chk("rst pc_M", pc_M, 0);
        chk("rst pc8_M", pc8_M, 8);
        chk("rst alu_out_M", alu_out_M, 0);
        chk("rst rt_data_M", rt_data_M, 0);
        chk("rst a3_M", a3_M, 0);
        chk("rst tnew_M", tnew_M, 0);
        chk("rst valid_M", valid_M, 0);
`ifdef EM_PERF_CNT_EN
        chk("rst bubble_cnt_M", bubble_cnt_M, 0);
        chk("rst stall_cnt_M", stall_cnt_M, 0);
        chk("rst store_cnt_M", store_cnt_M, 0);
`endif
        q.delete();
        mdl_clear_fields();
        mdl.bc = 0; mdl.sc = 0; mdl.stc = 0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst held valid_M", valid_M, 0);
        @(negedge clk);
        reset_n = 1'b1;
        in_reset = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] ins;
        do_reset();

        // Load of a lw, then saturation cases for Tnew.
        cyc(0, 0, 1, 32'h8C22_0004, 32'h0000_3004, 5'd2, 2'd2);
        cyc(0, 0, 1, 32'h8C23_0008, 32'h0000_3008, 5'd3, 2'd0);
        cyc(0, 0, 1, 32'h8C24_000C, 32'h0000_300C, 5'd4, 2'd1);
        cyc(0, 0, 1, 32'h0085_2820, 32'h0000_3010, 5'd5, 2'd3);
        // Stall for three edges while E changes.
        cyc(1, 0, 1, 32'h1111_1111, 32'h0000_4000, 5'd9, 2'd1);
        cyc(1, 0, 0, 32'h2222_2222, 32'h0000_4004, 5'd10, 2'd2);
        cyc(1, 0, 1, 32'h3333_3333, 32'h0000_4008, 5'd11, 2'd0);
        // Flush together with stall, then an empty E slot.
        cyc(1, 1, 1, 32'h8C22_0004, 32'h0000_5000, 5'd12, 2'd2);
        cyc(0, 0, 0, 32'h8C22_0004, 32'h0000_5004, 5'd13, 2'd2);
        // Store at the top of the address space; a3 = 0 capture.
        cyc(0, 0, 1, 32'hAC22_0000, 32'hFFFF_FFFC, 5'd0, 2'd3);
        cyc(0, 0, 1, 32'hAC22_0010, 32'hFFFF_FFF8, 5'd0, 2'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) == 0) ins[31:26] = 6'b101011;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) != 0, ins, $urandom,
                5'($urandom), 2'($urandom));
            if (i == 200) do_reset();
        end

        cyc(0, 0, 1, 32'hAC00_0000, 32'h0000_0100, 5'd1, 2'd2);
        repeat (2) @(posedge clk);
        #2;
        chk("queue drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
